// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit path.
// Holds the default sizing constants, the exit FSM state encoding and the
// token decode helper used by the entry and exit sides.
package parking_pkg;

  localparam int unsigned NumSlots = 8;
  localparam int unsigned SlotW    = $clog2(NumSlots);
  localparam int unsigned TimeW    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StResp,
    StWaitLow
  } exit_state_e;

  // Tokens are slot numbers scrambled with a shared pattern; XOR is its own inverse.
  function automatic logic [SlotW-1:0] decode_token(input logic [SlotW-1:0] token,
                                                    input logic [SlotW-1:0] pattern);
    return token ^ pattern;
  endfunction

endpackage

// File: rtl/parking_slot_table.sv
// Occupancy bitmap and per-slot entry timestamp register file.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   set_en/set_slot    entry request; accepted only if the slot is free before the edge
//   set_time           timestamp stored for an accepted entry
//   set_rej            one-cycle pulse after an entry that hit an occupied slot
//   clr_en/clr_slot    free a slot on this edge
//   rd_slot/rd_time    combinational read of a stored entry time
//   capacity           occupancy bitmap (bit i = slot i occupied)
//   parked/empty       occupied and free slot counts
module parking_slot_table
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NumSlots,
  parameter int unsigned TIME_W    = TimeW,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [SLOT_W-1:0]    set_slot,
  input  logic [TIME_W-1:0]    set_time,
  output logic                 set_rej,
  input  logic                 clr_en,
  input  logic [SLOT_W-1:0]    clr_slot,
  input  logic [SLOT_W-1:0]    rd_slot,
  output logic [TIME_W-1:0]    rd_time,
  output logic [NUM_SLOTS-1:0] capacity,
  output logic [3:0]           parked,
  output logic [3:0]           empty
);

  logic [NUM_SLOTS-1:0] bitmap_q, bitmap_d;
  logic [TIME_W-1:0]    entry_time_q [NUM_SLOTS];
  logic                 rej_q, rej_d;
  logic                 set_ok;
  logic [3:0]           count;

  // Entries are judged against the pre-edge bitmap, so an entry racing a
  // clear of the same slot is still rejected.
  assign set_ok = set_en & ~bitmap_q[set_slot];

  always_comb begin
    bitmap_d = bitmap_q;
    rej_d    = set_en & bitmap_q[set_slot];
    if (clr_en) bitmap_d[clr_slot] = 1'b0;
    if (set_ok) bitmap_d[set_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q <= '0;
      rej_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) entry_time_q[i] <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      rej_q    <= rej_d;
      if (set_ok) entry_time_q[set_slot] <= set_time;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) count = count + 4'(bitmap_q[i]);
  end

  assign rd_time  = entry_time_q[rd_slot];
  assign capacity = bitmap_q;
  assign parked   = count;
  assign empty    = 4'(NUM_SLOTS) - count;
  assign set_rej  = rej_q;

endmodule

// File: rtl/parking_checkout.sv
// Exit-side parking controller: owns the slot table, decodes exit tokens,
// frees occupied slots and reports the parked duration.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   time_now                 free-running time
//   entry_valid/entry_slot   entry strobe from the allocation path
//   entry_rej                pulse when an entry targets an occupied slot
//   exit_req                 level request, held until ack/err is seen
//   exit_token, pattern      token and scramble pattern
//   exit_ack / exit_err      one-cycle response pulses
//   slot, time_total         decoded slot and duration, held until next lookup
//   capacity, parked, empty  occupancy bitmap and counts
module parking_checkout
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NumSlots,
  parameter int unsigned TIME_W    = TimeW,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TIME_W-1:0]    time_now,
  input  logic                 entry_valid,
  input  logic [SLOT_W-1:0]    entry_slot,
  output logic                 entry_rej,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_token,
  input  logic [SLOT_W-1:0]    pattern,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic [SLOT_W-1:0]    slot,
  output logic [TIME_W-1:0]    time_total,
  output logic [NUM_SLOTS-1:0] capacity,
  output logic [3:0]           parked,
  output logic [3:0]           empty
);

  exit_state_e       state_q, state_d;
  logic [SLOT_W-1:0] token_q, token_d;
  logic [SLOT_W-1:0] pattern_q, pattern_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [TIME_W-1:0] time_total_q, time_total_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              clr_en;
  logic [SLOT_W-1:0] lookup_slot;
  logic [TIME_W-1:0] rd_time;

  assign lookup_slot = decode_token(token_q, pattern_q);

  parking_slot_table #(
    .NUM_SLOTS(NUM_SLOTS),
    .TIME_W   (TIME_W)
  ) u_slot_table (
    .clk     (clk),
    .rst     (rst),
    .set_en  (entry_valid),
    .set_slot(entry_slot),
    .set_time(time_now),
    .set_rej (entry_rej),
    .clr_en  (clr_en),
    .clr_slot(lookup_slot),
    .rd_slot (lookup_slot),
    .rd_time (rd_time),
    .capacity(capacity),
    .parked  (parked),
    .empty   (empty)
  );

  always_comb begin
    state_d      = state_q;
    token_d      = token_q;
    pattern_d    = pattern_q;
    slot_d       = slot_q;
    time_total_d = time_total_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    clr_en       = 1'b0;
    case (state_q)
      StIdle: begin
        if (exit_req) begin
          token_d   = exit_token;
          pattern_d = pattern;
          state_d   = StLookup;
        end
      end
      StLookup: begin
        slot_d = lookup_slot;
        if (capacity[lookup_slot]) begin
          clr_en       = 1'b1;
          ack_d        = 1'b1;
          // Wraps modulo 2^TIME_W so a time_now rollover still gives the true duration.
          time_total_d = time_now - rd_time;
        end else begin
          err_d        = 1'b1;
          time_total_d = '0;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = exit_req ? StWaitLow : StIdle;
      end
      StWaitLow: begin
        if (!exit_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      token_q      <= '0;
      pattern_q    <= '0;
      slot_q       <= '0;
      time_total_q <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      token_q      <= token_d;
      pattern_q    <= pattern_d;
      slot_q       <= slot_d;
      time_total_q <= time_total_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign exit_ack   = ack_q;
  assign exit_err   = err_q;
  assign slot       = slot_q;
  assign time_total = time_total_q;

endmodule
